nes_controller_responder: RTL and testbench

Emulates a standard NES controller on the latch/pulse/data serial link, i.e. the device end of the protocol that `controller_nes` drives. It samples the host's `latch` and `pulse` lines, snapshots an 8-bit button vector, and shifts it out active-low one bit per pulse. It lets a second FPGA, a test fixture, or an on-board stimulus source stand in for a physical pad, and exercises the host reader end-to-end.

---
 rtl/nes_controller_responder_if.sv | 20 ++
 rtl/nes_controller_responder.sv | 129 ++++++++++++
 tb/tb_nes_controller_responder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/nes_controller_responder_if.sv
// Latch/pulse/data link between a NES host reader and the pad-side responder.
// The host drives latch/pulse and a stimulus source drives buttons_in.
interface nes_controller_responder_if;
  logic       latch_in;
  logic       pulse_in;
  logic [0:7] buttons_in;
  logic       data_out;
  logic       poll_done;
  logic [3:0] bit_index;

  modport master (
    output latch_in, pulse_in, buttons_in,
    input  data_out, poll_done, bit_index
  );

  modport slave (
    input  latch_in, pulse_in, buttons_in,
    output data_out, poll_done, bit_index
  );
endinterface

// File: rtl/nes_controller_responder.sv
// Device end of the NES latch/pulse/data link: snapshots buttons on latch and shifts them out active-low.
// Optional turbo (define NES_RESP_TURBO_EN) periodically releases A and B on alternating poll groups.
module nes_controller_responder #(
  parameter int SYNC_STAGES  = 2,
  parameter int TURBO_PERIOD = 4
) (
  input logic                        clk,
  input logic                        rst,
  nes_controller_responder_if.slave  bus
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TURBO_PERIOD < 1) begin : g_param_check
    $error("nes_controller_responder: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                 state;
  logic [0:7]             shreg;
  logic [0:7]             load_val;
  logic [SYNC_STAGES-1:0] latch_sync;
  logic [SYNC_STAGES-1:0] pulse_sync;
  logic                   latch_prev;
  logic                   pulse_prev;
  logic                   latch_s;
  logic                   pulse_s;
  logic                   latch_rise;
  logic                   latch_fall;
  logic                   pulse_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch_sync <= '0;
      pulse_sync <= '0;
      latch_prev <= 1'b0;
      pulse_prev <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], bus.latch_in};
      pulse_sync <= {pulse_sync[SYNC_STAGES-2:0], bus.pulse_in};
      latch_prev <= latch_s;
      pulse_prev <= pulse_s;
    end
  end

  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign pulse_s    = pulse_sync[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_prev;
  assign latch_fall = ~latch_s & latch_prev;
  assign pulse_rise = pulse_s & ~pulse_prev;

`ifdef NES_RESP_TURBO_EN
  localparam int CNT_W = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;

  logic [CNT_W-1:0] turbo_cnt;
  logic             turbo_flag;

  // Every synchronized latch fall counts, including those of aborted polls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      turbo_cnt  <= '0;
      turbo_flag <= 1'b0;
    end else if (latch_fall) begin
      if (turbo_cnt == CNT_W'(TURBO_PERIOD - 1)) begin
        turbo_cnt  <= '0;
        turbo_flag <= ~turbo_flag;
      end else begin
        turbo_cnt <= turbo_cnt + 1'b1;
      end
    end
  end

  assign load_val = bus.buttons_in & ~{turbo_flag, turbo_flag, 6'b000000};
`else
  assign load_val = bus.buttons_in;
`endif

  // A latch rise pre-empts everything, including a pulse rise in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      shreg         <= '0;
      bus.data_out  <= 1'b1;
      bus.poll_done <= 1'b0;
      bus.bit_index <= '0;
    end else begin
      bus.poll_done <= 1'b0;
      if (latch_rise) begin
        state         <= LOAD;
        shreg         <= load_val;
        bus.data_out  <= ~load_val[0];
        bus.bit_index <= '0;
      end else begin
        case (state)
          IDLE: begin
            bus.data_out  <= 1'b1;
            bus.bit_index <= '0;
          end
          LOAD: begin
            if (latch_fall) begin
              state <= SHIFT;
            end else begin
              shreg        <= load_val;
              bus.data_out <= ~load_val[0];
            end
          end
          SHIFT: begin
            if (pulse_rise) begin
              shreg         <= {shreg[1:7], 1'b0};
              bus.bit_index <= bus.bit_index + 4'd1;
              if (bus.bit_index == 4'd7) begin
                state         <= DONE;
                bus.data_out  <= 1'b0;
                bus.poll_done <= 1'b1;
              end else begin
                bus.data_out <= ~shreg[1];
              end
            end
          end
          DONE: begin
            bus.data_out  <= 1'b0;
            bus.bit_index <= 4'd8;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nes_controller_responder.sv
// Directed bench for nes_controller_responder: host-side latch/pulse stimulus with hand-computed serial streams.
module tb_nes_controller_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;
  int pd_count = 0;
  int pd0;

  nes_controller_responder_if bus ();

  nes_controller_responder #(
    .SYNC_STAGES (2),
    .TURBO_PERIOD(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.poll_done === 1'b1) pd_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    bus.pulse_in = 1'b1;
    wait_cycles(6);
    bus.pulse_in = 1'b0;
    wait_cycles(6);
  endtask

  task automatic latch_cycle(input int high);
    bus.latch_in = 1'b1;
    wait_cycles(high);
    bus.latch_in = 1'b0;
    wait_cycles(6);
  endtask

  task automatic shift_check(input string tag, input logic [0:7] exp, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data_b%0d", tag, i), 32'(bus.data_out), 32'(exp[i]));
      check($sformatf("%s_idx_b%0d", tag, i), 32'(bus.bit_index), i);
      pulse();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.latch_in = 1'b0;
    bus.pulse_in = 1'b0;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(2);
  endtask

  logic [0:5] turbo_exp;

  initial begin
`ifdef NES_RESP_TURBO_EN
    turbo_exp = 6'b001100;
`else
    turbo_exp = 6'b000000;
`endif
    bus.latch_in   = 1'b0;
    bus.pulse_in   = 1'b0;
    bus.buttons_in = '0;

    // Reset values
    wait_cycles(1);
    check("rst_data", 32'(bus.data_out), 1);
    check("rst_done", 32'(bus.poll_done), 0);
    check("rst_idx", 32'(bus.bit_index), 0);
    rst = 1'b0;
    wait_cycles(2);

    // Latency: latch rise reaches data_out on the third edge
    do_reset();
    bus.buttons_in = 8'b1000_0000;
    wait_cycles(2);
    bus.latch_in = 1'b1;
    wait_cycles(1);
    check("lat_t1", 32'(bus.data_out), 1);
    wait_cycles(1);
    check("lat_t2", 32'(bus.data_out), 1);
    wait_cycles(1);
    check("lat_t3", 32'(bus.data_out), 0);
    bus.latch_in = 1'b0;
    wait_cycles(6);

    // Basic poll, A+Start
    do_reset();
    bus.buttons_in = 8'b1001_0000;
    pd0 = pd_count;
    latch_cycle(12);
    shift_check("basic", 8'b0110_1111, 8);
    check("basic_done_data", 32'(bus.data_out), 0);
    check("basic_done_idx", 32'(bus.bit_index), 8);
    check("basic_pd_once", pd_count - pd0, 1);
    pulse();
    check("done_ign_data", 32'(bus.data_out), 0);
    check("done_ign_idx", 32'(bus.bit_index), 8);
    check("done_ign_pd", pd_count - pd0, 1);

    // Buttons change late in latch; later changes during shift must not leak in
    do_reset();
    bus.buttons_in = '0;
    bus.latch_in = 1'b1;
    wait_cycles(10);
    bus.buttons_in = 8'b0000_0001;
    wait_cycles(2);
    bus.latch_in = 1'b0;
    wait_cycles(6);
    bus.buttons_in = 8'b1111_1110;
    shift_check("late_btn", 8'b1111_1110, 8);

    // Abort after 3 pulses, B pressed
    do_reset();
    bus.buttons_in = 8'b0100_0000;
    pd0 = pd_count;
    latch_cycle(12);
    shift_check("abort", 8'b1011_1111, 3);
    bus.latch_in = 1'b1;
    wait_cycles(6);
    check("abort_idx", 32'(bus.bit_index), 0);
    check("abort_data", 32'(bus.data_out), 1);
    check("abort_no_pd", pd_count - pd0, 0);
    bus.latch_in = 1'b0;
    wait_cycles(6);
    shift_check("rerun", 8'b1011_1111, 8);
    check("rerun_pd", pd_count - pd0, 1);

    // Reset mid-SHIFT
    do_reset();
    bus.buttons_in = 8'b1001_0000;
    pd0 = pd_count;
    latch_cycle(12);
    shift_check("pre_rst", 8'b0110_1111, 3);
    check("pre_rst_data", 32'(bus.data_out), 0);
    rst = 1'b1;
    #1;
    check("midrst_data", 32'(bus.data_out), 1);
    check("midrst_done", 32'(bus.poll_done), 0);
    check("midrst_idx", 32'(bus.bit_index), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(2);
    pulse();
    check("postrst_data", 32'(bus.data_out), 1);
    check("postrst_idx", 32'(bus.bit_index), 0);
    check("postrst_pd", pd_count - pd0, 0);

    // Turbo: A held over 6 polls
    do_reset();
    bus.buttons_in = 8'b1000_0000;
    for (int p = 0; p < 6; p++) begin
      latch_cycle(12);
      check($sformatf("turbo_p%0d", p), 32'(bus.data_out), 32'(turbo_exp[p]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
